// File: rtl/panel_pkg.sv
// Shared dimensions and helpers for the panel row capture block.
// Row layout: LED j, lane i occupies the COMP_W bits ending at row_msb(j, i).
package panel_pkg;

    localparam int NUM_LEDS  = 16;
    localparam int NUM_LANES = 3;
    localparam int COMP_W    = 8;
    localparam int WINDOW    = 2 ** COMP_W;
    localparam int LED_W     = NUM_LEDS * NUM_LANES;
    localparam int ROW_W     = LED_W * COMP_W;
    localparam int BCNT_W    = 5;

    function automatic int row_msb(input int led, input int lane);
        return ROW_W - 1 - (NUM_LANES * COMP_W) * led - COMP_W * lane;
    endfunction

    function automatic logic [COMP_W-1:0] sat_inc(input logic [COMP_W-1:0] v, input logic b);
        logic [COMP_W-1:0] r;
        if (b && (v != {COMP_W{1'b1}})) begin
            r = v + {{(COMP_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/panel_capture_if.sv
// Strobe, serial data and captured-state bundle between a panel driver and the capture block.
interface panel_capture_if;
    import panel_pkg::*;

    logic                 shift;
    logic                 load_led_vals;
    logic                 load_brightness;
    logic                 frame_sync;
    logic                 clear_error;
    logic [NUM_LANES-1:0] serial_data_in;
    logic [LED_W-1:0]     led_on;
    logic [LED_W-1:0]     brightness;
    logic [ROW_W-1:0]     row_colors_out;
    logic                 row_valid;
    logic                 length_error;

    modport master (
        output shift, load_led_vals, load_brightness, frame_sync, clear_error, serial_data_in,
        input  led_on, brightness, row_colors_out, row_valid, length_error
    );

    modport slave (
        input  shift, load_led_vals, load_brightness, frame_sync, clear_error, serial_data_in,
        output led_on, brightness, row_colors_out, row_valid, length_error
    );

endinterface

// File: rtl/panel_capture_lane.sv
// One colour lane: serial shift word plus a saturating on-count per LED.
// final_o is the count including the current load's bits, valid whenever step_i is high.
module panel_capture_lane
    import panel_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       shift_i,
    input  logic                       ser_i,
    input  logic                       step_i,
    input  logic                       sync_i,
    input  logic                       wrap_i,
    output logic [NUM_LEDS-1:0]        sreg_o,
    output logic [NUM_LEDS*COMP_W-1:0] final_o
);

    logic [NUM_LEDS-1:0]        sreg_q, sreg_d;
    logic [COMP_W-1:0]          cnt_q [NUM_LEDS];
    logic [COMP_W-1:0]          cnt_d [NUM_LEDS];
    logic [NUM_LEDS*COMP_W-1:0] final_s;

    // Per-LED count including this step; a sync restarts from zero
    always_comb begin
        final_s = {(NUM_LEDS*COMP_W){1'b0}};
        for (int j = 0; j < NUM_LEDS; j++) begin
            // LED j was shifted in j-th, so it sits at bit NUM_LEDS-1-j
            final_s[j*COMP_W +: COMP_W] = sat_inc(sync_i ? {COMP_W{1'b0}} : cnt_q[j],
                                                  sreg_q[NUM_LEDS-1-j]);
        end
    end

    // Shift register and counter next state
    always_comb begin
        if (shift_i) begin
            sreg_d = {sreg_q[NUM_LEDS-2:0], ser_i};
        end else begin
            sreg_d = sreg_q;
        end
        for (int j = 0; j < NUM_LEDS; j++) begin
            if (step_i) begin
                cnt_d[j] = wrap_i ? {COMP_W{1'b0}} : final_s[j*COMP_W +: COMP_W];
            end else if (sync_i) begin
                cnt_d[j] = {COMP_W{1'b0}};
            end else begin
                cnt_d[j] = cnt_q[j];
            end
        end
    end

    // Lane state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg_q <= {NUM_LEDS{1'b0}};
            for (int j = 0; j < NUM_LEDS; j++) begin
                cnt_q[j] <= {COMP_W{1'b0}};
            end
        end else begin
            sreg_q <= sreg_d;
            for (int j = 0; j < NUM_LEDS; j++) begin
                cnt_q[j] <= cnt_d[j];
            end
        end
    end

    assign sreg_o  = sreg_q;
    assign final_o = final_s;

endmodule

// File: rtl/panel_capture.sv
// Panel row receiver: deserialises R/G/B lanes, latches on/off and brightness words,
// and integrates on/off states over a PWM window to rebuild the row colour word.
module panel_capture
    import panel_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    panel_capture_if.slave bus
);

    logic [NUM_LEDS-1:0]        lane_sreg_s  [NUM_LANES];
    logic [NUM_LEDS*COMP_W-1:0] lane_final_s [NUM_LANES];

    logic [BCNT_W-1:0] bit_count_q, bit_count_d;
    logic [COMP_W-1:0] window_q, window_d;
    logic [LED_W-1:0]  led_on_q, led_on_d, bri_q, bri_d, remap_s;
    logic [ROW_W-1:0]  row_q, row_d, final_map_s;
    logic              row_valid_q, row_valid_d, err_q, err_d;
    logic              load_any_s, wrap_s, err_set_s;

    assign load_any_s = bus.load_led_vals | bus.load_brightness;
    assign wrap_s     = bus.load_led_vals & ~bus.frame_sync & (window_q == {COMP_W{1'b1}});
    assign err_set_s  = (load_any_s & (bit_count_q != BCNT_W'(NUM_LEDS)))
                      | (bus.load_led_vals & bus.load_brightness);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        panel_capture_lane u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .shift_i (bus.shift),
            .ser_i   (bus.serial_data_in[l]),
            .step_i  (bus.load_led_vals),
            .sync_i  (bus.frame_sync),
            .wrap_i  (wrap_s),
            .sreg_o  (lane_sreg_s[l]),
            .final_o (lane_final_s[l])
        );
    end

    // Lane words into LED-indexed layout and lane counts into row layout
    always_comb begin
        remap_s     = {LED_W{1'b0}};
        final_map_s = {ROW_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = 0; j < NUM_LEDS; j++) begin
                remap_s[i*NUM_LEDS + j] = lane_sreg_s[i][NUM_LEDS-1-j];
                final_map_s[row_msb(j, i) -: COMP_W] = lane_final_s[i][j*COMP_W +: COMP_W];
            end
        end
    end

    // Control next state: bit counter, window, latches, error
    always_comb begin
        if (load_any_s) begin
            bit_count_d = bus.shift ? 5'd1 : 5'd0;
        end else if (bus.shift && (bit_count_q != 5'd31)) begin
            bit_count_d = bit_count_q + 5'd1;
        end else begin
            bit_count_d = bit_count_q;
        end

        if (bus.frame_sync) begin
            window_d = bus.load_led_vals ? {{(COMP_W-1){1'b0}}, 1'b1} : {COMP_W{1'b0}};
        end else if (bus.load_led_vals) begin
            window_d = window_q + {{(COMP_W-1){1'b0}}, 1'b1};
        end else begin
            window_d = window_q;
        end

        led_on_d    = bus.load_led_vals ? remap_s : led_on_q;
        // A simultaneous on/off load takes the word, brightness keeps its old value
        bri_d       = (bus.load_brightness && !bus.load_led_vals) ? remap_s : bri_q;
        row_d       = wrap_s ? final_map_s : row_q;
        row_valid_d = wrap_s;

        if (err_set_s) begin
            err_d = 1'b1;
        end else if (bus.clear_error) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Top-level state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_count_q <= {BCNT_W{1'b0}};
            window_q    <= {COMP_W{1'b0}};
            led_on_q    <= {LED_W{1'b0}};
            bri_q       <= {LED_W{1'b0}};
            row_q       <= {ROW_W{1'b0}};
            row_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bit_count_q <= bit_count_d;
            window_q    <= window_d;
            led_on_q    <= led_on_d;
            bri_q       <= bri_d;
            row_q       <= row_d;
            row_valid_q <= row_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.led_on         = led_on_q;
    assign bus.brightness     = bri_q;
    assign bus.row_colors_out = row_q;
    assign bus.row_valid      = row_valid_q;
    assign bus.length_error   = err_q;

endmodule

// File: tb/tb_panel_capture.sv
// Directed bench for panel_capture: table of shift/load vectors plus PWM window sequences.
module tb_panel_capture;
    import panel_pkg::*;

    typedef struct {
        string       name;
        logic [15:0] w0, w1, w2;
        int          nsh;
        logic        ld, lb, clr;
        logic [47:0] e_led, e_bri;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    panel_capture_if bus();

    panel_capture dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    vec_t vecs [9];
    logic [ROW_W-1:0] exp_row;

    always @(negedge clk) if (bus.row_valid === 1'b1) pulses++;

    task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.shift = 1'b0; bus.load_led_vals = 1'b0; bus.load_brightness = 1'b0;
        bus.frame_sync = 1'b0; bus.clear_error = 1'b0; bus.serial_data_in = 3'b000;
    endtask

    // Shift n bits per lane, from bit n-1 down to bit 0 of each word
    task automatic shift_word(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            bus.shift = 1'b1;
            bus.serial_data_in = {w2[k], w1[k], w0[k]};
            @(negedge clk);
        end
        bus.shift = 1'b0;
        bus.serial_data_in = 3'b000;
    endtask

    // Transmitter model: LED0 R=0x00 G=0x80 B=0xFF, LED15 R=0x01; ON iff value > pwm_time
    task automatic win_load(input int p, input logic sync, input logic exp_v);
        logic [15:0] w0, w1, w2;
        w0 = 16'h0000; w1 = 16'h0000; w2 = 16'h0000;
        w0[0]  = (p < 1);
        w1[15] = (p < 128);
        w2[15] = (p < 255);
        shift_word(w0, w1, w2, 16);
        bus.load_led_vals = 1'b1;
        bus.frame_sync = sync;
        @(negedge clk);
        clear_inputs();
        chk("row_valid", {383'd0, bus.row_valid}, {383'd0, exp_v});
        if (exp_v) begin
            chk("row_colors", bus.row_colors_out, exp_row);
            chk("win_err", {383'd0, bus.length_error}, {ROW_W{1'b0}});
            @(negedge clk);
            chk("row_valid_single", {383'd0, bus.row_valid}, {ROW_W{1'b0}});
        end
    endtask

    task automatic chk_all_zero();
        chk("rst_led_on", {336'd0, bus.led_on}, {ROW_W{1'b0}});
        chk("rst_bright", {336'd0, bus.brightness}, {ROW_W{1'b0}});
        chk("rst_row", bus.row_colors_out, {ROW_W{1'b0}});
        chk("rst_valid", {383'd0, bus.row_valid}, {ROW_W{1'b0}});
        chk("rst_err", {383'd0, bus.length_error}, {ROW_W{1'b0}});
    endtask

    initial begin
        vecs[0] = '{"basic",   16'h8001, 16'h0000, 16'h0000, 16, 1'b1, 1'b0, 1'b0, 48'h0000_0000_8001, 48'h0000_0000_0000, 1'b0};
        vecs[1] = '{"bright",  16'h00F0, 16'h1234, 16'hFFFF, 16, 1'b0, 1'b1, 1'b0, 48'h0000_0000_8001, 48'hFFFF_2C48_0F00, 1'b0};
        vecs[2] = '{"led2",    16'h0001, 16'h8000, 16'h0003, 16, 1'b1, 1'b0, 1'b0, 48'hC000_0001_8000, 48'hFFFF_2C48_0F00, 1'b0};
        vecs[3] = '{"short15", 16'h0000, 16'h0000, 16'h0000, 15, 1'b1, 1'b0, 1'b0, 48'h0001_0000_0001, 48'hFFFF_2C48_0F00, 1'b1};
        vecs[4] = '{"clear",   16'h0000, 16'h0000, 16'h0000,  0, 1'b0, 1'b0, 1'b1, 48'h0001_0000_0001, 48'hFFFF_2C48_0F00, 1'b0};
        vecs[5] = '{"clr_bad", 16'h0000, 16'h0000, 16'h0000, 14, 1'b1, 1'b0, 1'b1, 48'h0000_0000_0000, 48'hFFFF_2C48_0F00, 1'b1};
        vecs[6] = '{"clear2",  16'h0000, 16'h0000, 16'h0000,  0, 1'b0, 1'b0, 1'b1, 48'h0000_0000_0000, 48'hFFFF_2C48_0F00, 1'b0};
        vecs[7] = '{"both",    16'h00FF, 16'h0000, 16'h0F0F, 16, 1'b1, 1'b1, 1'b0, 48'hF0F0_0000_FF00, 48'hFFFF_2C48_0F00, 1'b1};
        vecs[8] = '{"clear3",  16'h0000, 16'h0000, 16'h0000,  0, 1'b0, 1'b0, 1'b1, 48'hF0F0_0000_FF00, 48'hFFFF_2C48_0F00, 1'b0};

        exp_row = {ROW_W{1'b0}};
        exp_row[383:360] = 24'h0080FF;
        exp_row[23:16]   = 8'h01;

        clear_inputs();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero();
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            shift_word(vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].nsh);
            bus.load_led_vals = vecs[v].ld;
            bus.load_brightness = vecs[v].lb;
            bus.clear_error = vecs[v].clr;
            @(negedge clk);
            clear_inputs();
            chk({vecs[v].name, "_led"}, {336'd0, bus.led_on}, {336'd0, vecs[v].e_led});
            chk({vecs[v].name, "_bri"}, {336'd0, bus.brightness}, {336'd0, vecs[v].e_bri});
            chk({vecs[v].name, "_err"}, {383'd0, bus.length_error}, {383'd0, vecs[v].e_err});
        end

        // Shift in the load cycle: load sees the pre-shift word, bit_count restarts at 1
        shift_word(16'h1111, 16'h0000, 16'h0000, 16);
        bus.shift = 1'b1; bus.serial_data_in = 3'b111; bus.load_led_vals = 1'b1;
        @(negedge clk);
        clear_inputs();
        chk("shiftload_led", {336'd0, bus.led_on}, {336'd0, 48'h0000_0000_8888});
        chk("shiftload_err", {383'd0, bus.length_error}, {ROW_W{1'b0}});
        shift_word(16'h0000, 16'h0000, 16'h0000, 15);
        bus.load_led_vals = 1'b1;
        @(negedge clk);
        clear_inputs();
        chk("after15_led", {336'd0, bus.led_on}, {336'd0, 48'h0001_0001_0001});
        chk("after15_err", {383'd0, bus.length_error}, {ROW_W{1'b0}});

        // Full window from a clean reset, synced on pwm_time 0
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int idx = 0; idx < 256; idx++) win_load(idx, idx == 0, idx == 255);

        // Resync at load 100: the old boundary passes silently, the new one lands 256 loads later
        for (int idx = 0; idx < 356; idx++)
            win_load(idx < 100 ? idx : idx - 100, (idx == 0) || (idx == 100), idx == 355);

        // Partial window, then asynchronous reset discards everything
        for (int idx = 0; idx < 50; idx++) win_load(idx, 1'b0, 1'b0);
        shift_word(16'hFFFF, 16'hFFFF, 16'hFFFF, 16);
        bus.load_brightness = 1'b1;
        @(negedge clk);
        clear_inputs();
        chk("pre_rst_bri", {336'd0, bus.brightness}, {336'd0, 48'hFFFF_FFFF_FFFF});
        reset_n = 1'b0;
        #1;
        chk_all_zero();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int idx = 0; idx < 256; idx++) win_load(idx, 1'b0, idx == 255);

        chk("pulse_count", ROW_W'(pulses), ROW_W'(3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/panel_capture.md
Name: panel_capture

Overview:
- Receive-side counterpart of the panel serial driver.
- Deserialises the three per-colour serial lanes (R, G, B) of one panel row.
  - Latches on/off LED states on load_led_vals.
  - Latches brightness words on load_brightness.
- Integrates on/off states over a 256-load PWM window to reconstruct the 384-bit row colour word.
- Used as the on-board loopback/test-panel monitor and as the bench checker for the panel driver.

Parameters:
- NUM_LEDS, 16, LEDs per lane (shift word length).
- NUM_LANES, 3, colour lanes; lane 0 = R, 1 = G, 2 = B.
- COMP_W, 8, bits per colour component.
- WINDOW, 256, load_led_vals events per integration window (must equal 2**COMP_W).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- shift  in  1  shift strobe; one bit per lane captured per asserted cycle.
- load_led_vals  in  1  latch shift words as LED on/off states; counts one PWM step.
- load_brightness  in  1  latch shift words as brightness.
- frame_sync  in  1  restart integration window; pulsed with the load for pwm_time==0.
- clear_error  in  1  clears length_error.
- serial_data_in  in  3  lane serial data, bit i = lane i.
- led_on  out  48  latched on/off states, bit 16*lane+led.
- brightness  out  48  latched brightness words, same layout.
- row_colors_out  out  384  reconstructed colours.
  - LED j, lane i occupies [383-24j-8i -: 8].
- row_valid  out  1  one-cycle pulse when row_colors_out updates.
- length_error  out  1  sticky framing error.

Behaviour:
- Reset: all outputs, shift registers, counters and bit_count go to 0.
  - Reset mid-window discards partial counts.
- Shift:
  - When shift=1, each lane's 16-bit register shifts left, LSB <= serial_data_in[lane].
  - First bit of a word is LED0; after 16 shifts, bit 15 = LED0 and bit 0 = LED15.
  - bit_count (5 bits) increments per shift, saturating at 31.
- Load:
  - On load_led_vals, led_on <= current shift registers, remapped so LED j lands at bit 16*lane+j.
  - Load uses the pre-shift register value if shift is asserted in the same cycle.
  - bit_count <= shift ? 1 : 0.
  - load_brightness behaves the same but updates brightness.
  - Both loads asserted together: load_led_vals wins, brightness is unchanged, length_error is set.
  - Any load with bit_count != 16 sets length_error; the load still completes.
- Integration, per load_led_vals:
  - Each of 48 COMP_W-bit counters increments where its bit is 1, saturating at 255.
  - Window counter (8 bits) increments.
  - Load where window counter = 255 (256th load):
    - row_colors_out <= final counts, including this load's bits.
    - row_valid pulses the next cycle.
    - Counters and window counter clear.
  - Transmitter ON iff value > pwm_time over 256 steps, so count = value exactly.
- frame_sync:
  - Asserted alone: clears counters and window counter with no output update.
  - Asserted with load_led_vals: clears counters, then counts this load as step 0 (counters = this load's bits, window = 1).
- length_error:
  - Cleared by clear_error.
  - A simultaneous set takes priority over clear.
- Latency: led_on/brightness valid the cycle after the load; row_valid 1 cycle after the 256th load.

Decomposition:
- Shared package panel_pkg holds:
  - NUM_LEDS, NUM_LANES, COMP_W, ROW_W=384.
  - Index function for the row_colors slice (LED j, lane i).
- One natural sub-module: panel_capture_lane, instantiated per lane.
  - Contains the shift register and 16 saturating counters.
- Top level keeps bit_count, window counter, error logic and output assembly.

Test Plan:
- Reset, then shift 16 bits of 0x8001 on lane 0 and 0 elsewhere, then load_led_vals -> led_on[0]=1, led_on[15]=1, other bits 0, length_error=0.
- Full window: transmitter with LED0 R=0x00, G=0x80, B=0xFF and LED15 R=0x01, others 0, pwm_time sweeping 0..255 after frame_sync -> row_colors_out[383:360]=0x0080FF, [23:16]=0x01, single row_valid pulse.
- Load after only 15 shifts -> length_error=1, led_on still updates; clear_error -> 0; clear_error with a bad load in the same cycle -> stays 1.
- load_led_vals and load_brightness asserted in the same cycle -> led_on updated, brightness unchanged, length_error=1.
- Shift asserted in the same cycle as load_led_vals -> led_on reflects the pre-shift word, bit_count=1; 15 more shifts plus a load -> no error.
- frame_sync at load 100 of a window -> no row_valid at the original boundary; row_valid exactly 256 loads after the sync; reset_n asserted mid-window -> all outputs 0 immediately.
